// File: rtl/mips_bus_lsu.sv
// Avalon-MM load/store unit between the multi-cycle MIPS core and the bus: lane/mask generation, load alignment and extension, wait-state timeout.
// Latency: accept at N, strobes from N+1, resp_valid at N+2 plus one cycle per stalled bus cycle; illegal requests answer at N+1.
// Backpressure: one request in flight, req_ready only in IDLE; waitrequest holds the bus phase until it drops or the optional timeout fires.
// Optional build macro LSU_ALIGN_CHECK_EN: misaligned half/word/doubleword requests are answered with an error instead of being aligned down.
module mips_bus_lsu #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic                    read,
  output logic                    write,
  input  logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   readdata
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int LB    = $clog2(LANES);
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    is_store_q, is_store_d;
  logic [1:0]              size_q, size_d;
  logic                    signed_q, signed_d;
  logic [LB-1:0]           lane_q, lane_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic [DATA_WIDTH-1:0]   writedata_q, writedata_d;
  logic [LANES-1:0]        byteenable_q, byteenable_d;
  logic                    rd_stb_q, rd_stb_d;
  logic                    wr_stb_q, wr_stb_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;

  // Request decode helpers (only meaningful while IDLE)
  logic [LB-1:0]           req_lane;
  logic [LANES-1:0]        req_base_mask;
  logic                    req_illegal;

  // Load extraction helpers (only meaningful while ISSUE)
  int                      ld_bits;
  logic [DATA_WIDTH-1:0]   ld_shift;
  logic [DATA_WIDTH-1:0]   ld_mask;
  logic [DATA_WIDTH-1:0]   ld_top;
  logic                    ld_sign;
  logic [DATA_WIDTH-1:0]   ld_ext;

  // Wait counter helpers
  logic [CNT_W-1:0]        cnt_inc;
  logic                    timeout_hit;

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign address    = address_q;
  assign read       = rd_stb_q;
  assign write      = wr_stb_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;

  // Decode the offered request: aligned lane, base byte mask and legality
  always_comb begin
    req_lane      = req_addr[LB-1:0] & ({LB{1'b1}} << req_size);
    req_base_mask = LANES'(8'h01);
    case (req_size)
      2'b00:   req_base_mask = LANES'(8'h01);
      2'b01:   req_base_mask = LANES'(8'h03);
      2'b10:   req_base_mask = LANES'(8'h0F);
      default: req_base_mask = LANES'(8'hFF);
    endcase
    // A doubleword cannot be carried by a 32-bit bus
    req_illegal = (req_size == 2'b11) && (DATA_WIDTH == 32);
`ifdef LSU_ALIGN_CHECK_EN
    req_illegal = req_illegal || (|(req_addr[2:0] & ~(3'b111 << req_size)));
`endif
  end

  // Shift the selected lanes down and extend to full width
  always_comb begin
    ld_bits = 8 << size_q;
    if (ld_bits > DATA_WIDTH) begin
      ld_bits = DATA_WIDTH;
    end
    ld_shift = readdata >> {lane_q, 3'b000};
    ld_mask  = '0;
    ld_top   = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      ld_mask[i] = (i < ld_bits);
      ld_top[i]  = (i == ld_bits - 1);
    end
    ld_sign = |(ld_shift & ld_top);
    // Full-width accesses are passed through untouched
    if (signed_q && ld_sign && (ld_bits < DATA_WIDTH)) begin
      ld_ext = ld_shift | ~ld_mask;
    end else begin
      ld_ext = ld_shift & ld_mask;
    end
  end

  // Saturating stall count and timeout detection
  always_comb begin
    cnt_inc     = (wait_cnt_q == {CNT_W{1'b1}}) ? wait_cnt_q : wait_cnt_q + 1'b1;
    timeout_hit = (WAIT_TIMEOUT != 0) && (cnt_inc == CNT_W'(WAIT_TIMEOUT));
  end

  // Next-state and registered-output logic for the IDLE/ISSUE/RESP sequence
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    size_d       = size_q;
    signed_d     = signed_q;
    lane_d       = lane_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    rd_stb_d     = rd_stb_q;
    wr_stb_d     = wr_stb_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    wait_cnt_d   = wait_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          is_store_d = req_write;
          size_d     = req_size;
          signed_d   = req_signed;
          lane_d     = req_lane;
          wait_cnt_d = '0;
          if (req_illegal) begin
            // Answer immediately without touching the bus
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d      = S_ISSUE;
            address_d    = {req_addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
            writedata_d  = req_wdata << {req_lane, 3'b000};
            byteenable_d = req_base_mask << req_lane;
            rd_stb_d     = ~req_write;
            wr_stb_d     = req_write;
          end
        end
      end

      S_ISSUE: begin
        if (!waitrequest) begin
          state_d      = S_RESP;
          rd_stb_d     = 1'b0;
          wr_stb_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = is_store_q ? '0 : ld_ext;
        end else begin
          wait_cnt_d = cnt_inc;
          if (timeout_hit) begin
            state_d      = S_RESP;
            rd_stb_d     = 1'b0;
            wr_stb_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        rd_stb_d = 1'b0;
        wr_stb_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      is_store_q   <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      lane_q       <= '0;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      rd_stb_q     <= 1'b0;
      wr_stb_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      lane_q       <= lane_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      rd_stb_q     <= rd_stb_d;
      wr_stb_q     <= wr_stb_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_mips_bus_lsu.sv
// Self-checking bench for mips_bus_lsu (32-bit bus, 4-cycle wait timeout).
// Directed test-plan steps followed by randomized accesses against a byte-level reference model.
// Bus stalls are driven by the bench; readdata carries garbage while stalled.
module tb_mips_bus_lsu;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic          waitrequest;
  logic [DW-1:0] writedata;
  logic [3:0]    byteenable;
  logic [DW-1:0] readdata;

  int checks = 0;
  int errors = 0;

  mips_bus_lsu #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .WAIT_TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .address    (address),
    .read       (read),
    .write      (write),
    .waitrequest(waitrequest),
    .writedata  (writedata),
    .byteenable (byteenable),
    .readdata   (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: what a byte-addressed 32-bit bus access should look like
  function automatic void model(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                output bit ill, output logic [31:0] e_addr, output logic [3:0] e_be,
                                output logic [31:0] e_wd, output logic [31:0] e_rd);
    int bytes;
    int lane;
    int bits;
    logic [63:0] t;
    logic [63:0] v;
    bytes = 1 << sz;
    bits  = 8 * bytes;
    ill   = (sz == 2'b11);
`ifdef LSU_ALIGN_CHECK_EN
    if ((a % bytes) != 0) ill = 1'b1;
`endif
    lane   = ((a % 4) / bytes) * bytes;
    e_addr = a - (a % 4);
    t      = ((64'd1 << bytes) - 64'd1) << lane;
    e_be   = t[3:0];
    t      = {32'd0, wd} << (8 * lane);
    e_wd   = t[31:0];
    v      = ({32'd0, rd} >> (8 * lane)) & ((64'd1 << bits) - 64'd1);
    if (sg && bytes < 4 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    e_rd   = (wr || ill) ? 32'd0 : v[31:0];
  endfunction

  task automatic run_access(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                            input int stall);
    bit ill;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    model(wr, sz, sg, a, wd, rd, ill, e_addr, e_be, e_wd, e_rd);
    chk({tag, ".ready_pre"}, 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    tick();
    // Scramble request fields: they must be ignored while busy
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    if (ill) begin
      chk({tag, ".ill_vld"}, 64'(resp_valid), 64'd1);
      chk({tag, ".ill_err"}, 64'(resp_err), 64'd1);
      chk({tag, ".ill_rd"}, 64'(read), 64'd0);
      chk({tag, ".ill_wr"}, 64'(write), 64'd0);
      chk({tag, ".ill_rdata"}, 64'(resp_rdata), 64'd0);
      tick();
      chk({tag, ".ill_vld_off"}, 64'(resp_valid), 64'd0);
      chk({tag, ".ill_rd2"}, 64'(read), 64'd0);
      chk({tag, ".ill_ready"}, 64'(req_ready), 64'd1);
      return;
    end
    for (int k = 0; k <= stall; k++) begin
      chk({tag, ".read"}, 64'(read), 64'(!wr));
      chk({tag, ".write"}, 64'(write), 64'(wr));
      chk({tag, ".address"}, 64'(address), 64'(e_addr));
      chk({tag, ".be"}, 64'(byteenable), 64'(e_be));
      if (wr) chk({tag, ".wdata"}, 64'(writedata), 64'(e_wd));
      chk({tag, ".vld_early"}, 64'(resp_valid), 64'd0);
      chk({tag, ".ready_busy"}, 64'(req_ready), 64'd0);
      waitrequest = (k < stall);
      readdata    = (k < stall) ? ~rd : rd;
      tick();
    end
    waitrequest = 1'b0;
    readdata    = $urandom;
    chk({tag, ".resp_vld"}, 64'(resp_valid), 64'd1);
    chk({tag, ".resp_err"}, 64'(resp_err), 64'd0);
    chk({tag, ".resp_rdata"}, 64'(resp_rdata), 64'(e_rd));
    chk({tag, ".strobe_off"}, 64'({read, write}), 64'd0);
    tick();
    chk({tag, ".vld_pulse"}, 64'(resp_valid), 64'd0);
    chk({tag, ".ready_post"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int cnt;
    logic [1:0] sz;
    reset       = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'b00;
    req_signed  = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    waitrequest = 1'b0;
    readdata    = '0;

    // Reset state
    tick();
    tick();
    chk("rst.ready", 64'(req_ready), 64'd1);
    chk("rst.strobes", 64'({read, write}), 64'd0);
    chk("rst.resp", 64'({resp_valid, resp_err}), 64'd0);
    chk("rst.address", 64'(address), 64'd0);
    chk("rst.wdata", 64'(writedata), 64'd0);
    chk("rst.be", 64'(byteenable), 64'd0);
    chk("rst.rdata", 64'(resp_rdata), 64'd0);
    reset = 1'b1;
    tick();

    // Directed test-plan accesses
    run_access("word_load", 1'b0, 2'b10, 1'b0, 32'hBFC00004, 32'h0, 32'h8C020010, 0);
    run_access("sbyte_load", 1'b0, 2'b00, 1'b1, 32'h00001003, 32'h0, 32'h80FF1234, 0);
    run_access("ubyte_load", 1'b0, 2'b00, 1'b0, 32'h00001003, 32'h0, 32'h80FF1234, 0);
    run_access("half_store", 1'b1, 2'b01, 1'b0, 32'h00002002, 32'h0000BEEF, 32'h0, 3);
    run_access("shalf_load", 1'b0, 2'b01, 1'b1, 32'h00000002, 32'h0, 32'h9ABC1234, 1);
    run_access("misaligned", 1'b0, 2'b10, 1'b0, 32'h00001001, 32'h0, 32'h11223344, 0);
    run_access("dword_ill", 1'b0, 2'b11, 1'b0, 32'h00003000, 32'h0, 32'h0, 0);

    // Timeout with waitrequest stuck high
    waitrequest = 1'b1;
    readdata    = 32'hDEADBEEF;
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_size    = 2'b10;
    req_signed  = 1'b0;
    req_addr    = 32'h00004000;
    tick();
    req_valid = 1'b0;
    cnt = 0;
    while (read && cnt < 20) begin
      chk("to.no_resp", 64'(resp_valid), 64'd0);
      cnt++;
      tick();
    end
    chk("to.read_cycles", 64'(cnt), 64'(TO));
    chk("to.resp_vld", 64'(resp_valid), 64'd1);
    chk("to.resp_err", 64'(resp_err), 64'd1);
    chk("to.rdata", 64'(resp_rdata), 64'd0);
    chk("to.strobes", 64'({read, write}), 64'd0);
    waitrequest = 1'b0;
    tick();
    chk("to.ready", 64'(req_ready), 64'd1);
    chk("to.vld_off", 64'(resp_valid), 64'd0);

    // Reset while stalled in the bus phase
    waitrequest = 1'b1;
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_size    = 2'b10;
    req_addr    = 32'h00005000;
    req_wdata   = 32'hCAFEF00D;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rs.write_before", 64'(write), 64'd1);
    reset = 1'b0;
    tick();
    chk("rs.strobes", 64'({read, write}), 64'd0);
    chk("rs.vld", 64'(resp_valid), 64'd0);
    chk("rs.ready_in_rst", 64'(req_ready), 64'd1);
    reset       = 1'b1;
    waitrequest = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rs.no_resp", 64'(resp_valid), 64'd0);
    end
    chk("rs.ready", 64'(req_ready), 64'd1);

    // Randomized accesses against the reference model
    for (int t = 0; t < 60; t++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_access("rnd", 1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 3)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick();
        chk("rnd.idle_vld", 64'(resp_valid), 64'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_bus_lsu.md
# mips_bus_lsu

Parametrised Avalon-MM load/store unit that sits between the multi-cycle MIPS core and the external bus. It accepts one request at a time: instruction fetch, word/half/byte load or store, or a doubleword access in 64-bit builds. It drives the bus and holds the access through `waitrequest`. It also generates byte lanes, then aligns and sign- or zero-extends read data. It replaces the ad-hoc `address`/`byteenable`/extension logic in the core, and adds a wait-state timeout and a bus-error response.

## Interface
Parameters:
- `DATA_WIDTH`, 32: bus data width.
  - Legal values are 32 and 64.
  - `LANES = DATA_WIDTH/8`.
  - `LB = log2(LANES)`.
- `ADDR_WIDTH`, 32: byte address width.
- `WAIT_TIMEOUT`, 0: maximum consecutive `waitrequest`-high cycles before the unit aborts with an error. 0 disables the timeout.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load/fetch.
- `req_size`  in  2  transfer size: 00 byte, 01 half, 10 word, 11 doubleword.
- `req_signed`  in  1  sign-extend load result.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  DATA_WIDTH  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- `resp_err`  out  1  qualifies `resp_valid`: access failed.
- `address`  out  ADDR_WIDTH  bus address, with the low LB bits forced to 0.
- `read`, `write`  out  1  Avalon strobes.
- `waitrequest`  in  1  slave stall.
- `writedata`  out  DATA_WIDTH  lane-shifted store data.
- `byteenable`  out  LANES  active byte lanes.
- `readdata`  in  DATA_WIDTH  valid in the cycle `read`=1 and `waitrequest`=0.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` the unit captures all `req_*` fields and moves to ISSUE.
  - A captured illegal request moves to RESP with error instead.
- Illegal requests:
  - `req_size`=11 when `DATA_WIDTH`=32.
  - Misaligned addresses when `LSU_ALIGN_CHECK_EN` is defined.
- ISSUE:
  - `read` or `write` is asserted.
  - `address`, `writedata` and `byteenable` are held stable.
  - A cycle with `waitrequest`=0 completes the transfer. On a load, `readdata` is latched. The FSM moves to RESP.
- Timeout: the wait counter counts cycles in ISSUE with `waitrequest`=1. When it reaches `WAIT_TIMEOUT` (non-zero), the strobes drop, the FSM moves to RESP and `resp_err` is set.
- RESP: `resp_valid`=1 for exactly one cycle, then the FSM returns to IDLE.
- Lane and mask:
  - `lane = addr[LB-1:0]` after size alignment.
  - `byteenable = base_mask << lane`, where `base_mask` is 1, 3, F or FF for byte, half, word and doubleword.
  - `writedata = req_wdata << (8*lane)`.
- Load data: `resp_rdata = extend((readdata >> 8*lane) & size_mask)`, extended with sign or zero as `req_signed` selects. Doubleword and full-width loads are not extended.
- `req_*` inputs are ignored whenever `req_ready`=0.

## Timing
- After reset: `req_ready`=1. `read`, `write`, `resp_valid`, `resp_err`, `address`, `writedata`, `byteenable` and `resp_rdata` are all 0. The wait counter is 0.
- Accept in cycle N. Strobes are high from N+1. If `waitrequest` is low at N+1, `resp_valid` is high at N+2 and `req_ready` is high at N+3.
- Each stalled cycle adds 1 to the latency.
- Peak throughput is one access per 3 cycles.
- Illegal request accepted at N: `resp_valid`=1 and `resp_err`=1 at N+1, with no bus strobe at any point.
- `reset` low in any state: the FSM is in IDLE after that edge and the strobes are 0 after that edge. Any pending response is dropped and no `resp_valid` is emitted.
- The wait counter saturates and clears on entry to ISSUE.
- All outputs are registered except `req_ready`, which is decoded from the state.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - Half with `addr[0]`=1 → error.
  - Word with `addr[1:0]`≠0 → error.
  - Doubleword with `addr[2:0]`≠0 → error.
  - An error here means no bus cycle is issued.
- Macro undefined: the low address bits below the size's natural alignment are silently cleared. The access proceeds at the aligned address and no error is raised.

## Test plan
- Word load, `DATA_WIDTH`=32:
  - Stimulus: `addr`=0xBFC00004, `waitrequest`=0, `readdata`=0x8C020010.
  - Required: `address`=0xBFC00004, `byteenable`=F, `resp_valid` at N+2, `resp_rdata`=0x8C020010.
- Signed byte load:
  - Stimulus: `addr`=0x1003, `readdata`=0x80FF1234.
  - Required: `byteenable`=8, `resp_rdata`=0xFFFFFF80. Repeating with `req_signed`=0 gives 0x00000080.
- Half store:
  - Stimulus: `addr`=0x2002, `req_wdata`=0x0000BEEF, `waitrequest` high for 3 cycles.
  - Required: `writedata`=0xBEEF0000 and `byteenable`=C, held for 4 cycles. `resp_valid` at N+5 with `resp_err`=0.
- Timeout:
  - Stimulus: `WAIT_TIMEOUT`=4, `waitrequest` stuck at 1.
  - Required: `read` high for exactly 4 cycles, then `resp_valid`=1, `resp_err`=1, `resp_rdata`=0.
- Misaligned word load at 0x1001:
  - With `LSU_ALIGN_CHECK_EN`: error at N+1 and no `read`.
  - Without the macro: `address`=0x1000, `byteenable`=F, `resp_err`=0.
- Reset mid-stall:
  - Stimulus: `reset` driven low during ISSUE.
  - Required: strobes 0 at the next edge, `resp_valid` never asserts, `req_ready`=1 after `reset` goes high again.
